// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid port plus the
// valid/ready instruction port toward decode.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [31:0]     imem_rdata_i;
   logic            instr_valid_o;
   logic            instr_ready_i;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] pc_o;

   // Fetch unit side
   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
   );

   // Memory / decode side
   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time,
// presents the fetched instruction to decode and redirects on retire.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             branch_taken_i,
   input  logic [XLEN-1:0]  branch_target_i,
   input  logic             jump_i,
   input  logic [XLEN-1:0]  jump_target_i,
   output logic [63:0]      instret_o,
   fetch_unit_if.master     bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [63:0]     instret_q, instret_d;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_pc;

   // Redirect selection: jump beats branch beats sequential; result word aligned
   always_comb begin
      if (jump_i)              target = jump_target_i;
      else if (branch_taken_i) target = branch_target_i;
      else                     target = pc_q + XLEN'(4);
      next_pc = target & ~XLEN'(3);
   end

   // Next-state logic; only the VALID handshake advances the PC
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      instret_d = instret_q;
      unique case (state_q)
         IDLE:  state_d = REQ;
         REQ:   if (bus.imem_gnt_i) state_d = WAIT;
         WAIT:  if (bus.imem_rvalid_i) begin
                   instr_d = bus.imem_rdata_i;
                   state_d = VALID;
                end
         VALID: if (bus.instr_ready_i) begin
                   pc_d      = next_pc;
                   instret_d = instret_q + 64'd1;
                   state_d   = REQ;
                end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset drops any in-flight transaction
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
      end
   end

   // Outputs are zeroed whenever they are not qualified
   assign bus.imem_req_o    = (state_q == REQ);
   assign bus.imem_addr_o   = (state_q == REQ) ? pc_q : '0;
   assign bus.instr_valid_o = (state_q == VALID);
   assign bus.instr_o       = (state_q == VALID) ? instr_q : '0;
   assign bus.pc_o          = (state_q == VALID) ? pc_q : '0;
   assign instret_o         = instret_q;

endmodule
